sfft_stream_bridge: RTL and testbench

Parametrised bridge between the audio codec driver, the SFFT pipeline and the 8-bit host slave bus.
- Front end: per-advance stereo-to-mono conversion with selectable channel mode and programmable decimation.
- Back end: byte-addressed readout of FFT bins with a registered 2-cycle read latency.
- Also maintains a frame counter with a host-controlled snapshot lock and a lock watchdog.

---
 rtl/sfft_stream_bridge_if.sv | 12 +
 rtl/sfft_stream_bridge.sv | 135 +++++++++++++
 tb/tb_sfft_stream_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sfft_stream_bridge_if.sv
// sfft_stream_bridge_if: 8-bit host slave bus with 2-cycle read latency
interface sfft_stream_bridge_if #(parameter int ADDR_W = 16);
   logic              chipselect;
   logic              write;
   logic              read;
   logic [ADDR_W-1:0] address;
   logic [7:0]        writedata;
   logic [7:0]        readdata;
   logic              readdatavalid;
   modport master (output chipselect, write, read, address, writedata, input readdata, readdatavalid);
   modport slave  (input chipselect, write, read, address, writedata, output readdata, readdatavalid);
endinterface

// File: rtl/sfft_stream_bridge.sv
// sfft_stream_bridge: codec-to-SFFT sample conditioning, frame counter with snapshot lock, host readout of FFT bins
module sfft_stream_bridge #(
   parameter int SAMPLE_W     = 24,
   parameter int OUT_W        = 32,
   parameter int NFFT_LOG2    = 9,
   parameter int CNT_W        = 32,
   parameter int ADDR_W       = 16,
   parameter int HOLD_TIMEOUT = 50000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 advance,
   input  logic [SAMPLE_W-1:0]  adc_left,
   input  logic [SAMPLE_W-1:0]  adc_right,
   output logic [SAMPLE_W-1:0]  sample_out,
   output logic                 sample_valid,
   input  logic                 frame_valid,
   input  logic                 read_error,
   output logic [NFFT_LOG2-1:0] bin_addr,
   input  logic [OUT_W-1:0]     bin_data,
   output logic                 output_being_read,
   sfft_stream_bridge_if.slave  bus
);
   localparam int BB = OUT_W / 8;
   localparam int RB = (1 << NFFT_LOG2) * BB;
   localparam logic [ADDR_W-1:0] RBA = ADDR_W'(RB);
   localparam int WD_W = $clog2(HOLD_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(HOLD_TIMEOUT - 1);
   logic [1:0]          mode;
   logic [7:0]          decim, dec_cnt, dec_last;
   logic [SAMPLE_W:0]   sum, dif;
   logic [SAMPLE_W-1:0] cond;
   logic                fv_q, lock, timeout;
   logic [CNT_W-1:0]    live, shadow;
   logic [WD_W-1:0]     wd;
   logic                wr, rd_acc, w_hit, r_hit;
   logic [ADDR_W-1:0]   woff, roff, a1, boff;
   logic [2:0]          wi, ri;
   logic                v1;
   logic [31:0]         cnt_rd;
   logic [7:0]          bin_byte, rd_mux;
   // Sums and differences are formed one bit wider so the halving never overflows.
   always_comb begin
      sum      = {adc_left[SAMPLE_W-1], adc_left} + {adc_right[SAMPLE_W-1], adc_right};
      dif      = {adc_left[SAMPLE_W-1], adc_left} - {adc_right[SAMPLE_W-1], adc_right};
      cond     = mode == 2'd0 ? SAMPLE_W'(sum >> 1) : mode == 2'd1 ? adc_left :
                 mode == 2'd2 ? adc_right : SAMPLE_W'(dif >> 1);
      dec_last = decim == 8'd0 ? 8'd0 : decim - 8'd1;
   end
   always_comb begin
      wr     = bus.chipselect & bus.write;
      rd_acc = bus.chipselect & bus.read & ~bus.write;
      woff   = bus.address - RBA;
      w_hit  = wr && bus.address >= RBA && woff < ADDR_W'(8);
      wi     = woff[2:0];
   end
   assign bin_addr          = NFFT_LOG2'(bus.address / ADDR_W'(BB));
   assign output_being_read = lock;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode         <= 2'd0;
         decim        <= 8'd1;
         dec_cnt      <= 8'd0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (w_hit && wi == 3'd5) mode <= bus.writedata[1:0];
         if (w_hit && wi == 3'd6) begin
            decim   <= bus.writedata;
            dec_cnt <= 8'd0;
         end else if (advance) begin
            if (dec_cnt >= dec_last) begin
               dec_cnt      <= 8'd0;
               sample_out   <= cond;
               sample_valid <= 1'b1;
            end else dec_cnt <= dec_cnt + 8'd1;
         end
      end
   end
   // Shadow samples the pre-edge count so a same-cycle frame edge lands only in the live counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fv_q    <= 1'b0;
         live    <= '0;
         shadow  <= '0;
         lock    <= 1'b0;
         timeout <= 1'b0;
         wd      <= '0;
      end else begin
         fv_q <= frame_valid;
         if (frame_valid && !fv_q) live <= live + 1'b1;
         if (w_hit && wi == 3'd4) timeout <= 1'b0;
         if (w_hit && wi == 3'd7) begin
            if (bus.writedata[0]) begin
               if (!lock) shadow <= live;
               lock <= 1'b1;
               wd   <= '0;
            end else lock <= 1'b0;
         end else if (lock) begin
            if (wd == WD_LAST) begin
               lock    <= 1'b0;
               timeout <= 1'b1;
            end else wd <= wd + 1'b1;
         end
      end
   end
   always_comb begin
      roff     = a1 - RBA;
      r_hit    = a1 >= RBA && roff < ADDR_W'(8);
      ri       = roff[2:0];
      boff     = a1 % ADDR_W'(BB);
      cnt_rd   = 32'(lock ? shadow : live);
      bin_byte = 8'(bin_data >> {boff, 3'b000});
      rd_mux   = a1 < RBA ? bin_byte :
                 !r_hit ? 8'h00 :
                 ri < 3'd4 ? 8'(cnt_rd >> {ri[1:0], 3'b000}) :
                 ri == 3'd4 ? {5'b0, timeout, lock, ~read_error} :
                 ri == 3'd5 ? {6'b0, mode} :
                 ri == 3'd6 ? decim : {7'b0, lock};
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1                <= 1'b0;
         a1                <= '0;
         bus.readdata      <= 8'h00;
         bus.readdatavalid <= 1'b0;
      end else begin
         v1                <= rd_acc;
         a1                <= bus.address;
         bus.readdatavalid <= v1;
         if (v1) bus.readdata <= rd_mux;
      end
   end
endmodule

// File: tb/tb_sfft_stream_bridge.sv
// tb_sfft_stream_bridge: directed and randomized checks of sfft_stream_bridge against a behavioural model
module tb_sfft_stream_bridge;
   localparam int SW = 24, OW = 32, NL = 9, CW = 8, AW = 16, HT = 100;
   localparam int RB = (1 << NL) * (OW / 8);
   logic clk = 1'b0, reset = 1'b1, advance = 1'b0, frame_valid = 1'b0, read_error = 1'b1;
   logic [SW-1:0] adc_left = '0, adc_right = '0, sample_out;
   logic sample_valid, output_being_read;
   logic [NL-1:0] bin_addr;
   logic [OW-1:0] bin_data = '0;
   logic [OW-1:0] mem [1 << NL];
   int checks = 0, failures = 0;
   int cnt_m = 0;
   sfft_stream_bridge_if #(.ADDR_W(AW)) bus ();
   sfft_stream_bridge #(.SAMPLE_W(SW), .OUT_W(OW), .NFFT_LOG2(NL), .CNT_W(CW), .ADDR_W(AW),
      .HOLD_TIMEOUT(HT)) dut (
      .clk(clk), .reset(reset), .advance(advance), .adc_left(adc_left), .adc_right(adc_right),
      .sample_out(sample_out), .sample_valid(sample_valid), .frame_valid(frame_valid),
      .read_error(read_error), .bin_addr(bin_addr), .bin_data(bin_data),
      .output_being_read(output_being_read), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) bin_data <= mem[bin_addr];
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [SW-1:0] ref_sample(input int m, input logic [SW-1:0] l, input logic [SW-1:0] r);
      int sl, sr, v;
      sl = int'($signed(l));
      sr = int'($signed(r));
      v  = m == 0 ? (sl + sr) >>> 1 : m == 1 ? sl : m == 2 ? sr : (sl - sr) >>> 1;
      return SW'(v);
   endfunction
   task automatic bus_idle();
      bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
   endtask
   task automatic wr(input int a, input logic [7:0] d);
      @(negedge clk);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = AW'(a); bus.writedata = d;
      @(negedge clk);
      bus_idle();
   endtask
   task automatic rd(input int a, input logic [7:0] exp, input string tag);
      @(negedge clk);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = AW'(a);
      @(negedge clk);
      bus_idle();
      chk({tag, "_rdv_early"}, bus.readdatavalid, 1'b0);
      @(negedge clk);
      chk({tag, "_rdv"}, bus.readdatavalid, 1'b1);
      chk(tag, bus.readdata, exp);
   endtask
   task automatic adv(input logic [SW-1:0] l, input logic [SW-1:0] r, output logic sv, output logic [SW-1:0] so);
      @(negedge clk);
      advance = 1'b1; adc_left = l; adc_right = r;
      @(negedge clk);
      advance = 1'b0;
      sv = sample_valid; so = sample_out;
      @(negedge clk);
   endtask
   task automatic fedge();
      @(negedge clk); frame_valid = 1'b1;
      @(negedge clk); frame_valid = 1'b0;
      cnt_m = (cnt_m + 1) % (1 << CW);
   endtask
   initial begin
      logic sv;
      logic [SW-1:0] so, l, r;
      int m, d, n, a;
      logic [OW-1:0] w;
      for (int i = 0; i < (1 << NL); i++) mem[i] = $urandom;
      mem[5] = 32'hA1B2C3D4;
      bus_idle();
      bus.address = '0; bus.writedata = '0;
      repeat (3) @(negedge clk);
      chk("rst_sample_valid", sample_valid, 0);
      chk("rst_sample_out", sample_out, 0);
      chk("rst_rdv", bus.readdatavalid, 0);
      chk("rst_readdata", bus.readdata, 0);
      chk("rst_lock", output_being_read, 0);
      reset = 1'b0;
      rd(RB + 5, 8'h00, "rst_mode");
      rd(RB + 6, 8'h01, "rst_decim");
      rd(RB + 0, 8'h00, "rst_cnt");
      adv(24'h000010, 24'hFFFFF0, sv, so);
      chk("m0_valid", sv, 1);
      chk("m0_out", so, 24'h000000);
      chk("m0_valid_pulse", sample_valid, 0);
      wr(RB + 5, 8'h03);
      rd(RB + 5, 8'h03, "mode_rb");
      adv(24'h000010, 24'hFFFFF0, sv, so);
      chk("m3_out", so, 24'h000010);
      for (int i = 0; i < 16; i++) begin
         m = int'($urandom_range(0, 3));
         l = SW'($urandom); r = SW'($urandom);
         wr(RB + 5, 8'(m));
         adv(l, r, sv, so);
         chk("rand_valid", sv, 1);
         chk($sformatf("rand_m%0d_out", m), so, ref_sample(m, l, r));
      end
      wr(RB + 5, 8'h00);
      for (int k = 0; k < 2; k++) begin
         d = k == 0 ? 4 : int'($urandom_range(2, 5));
         wr(RB + 6, 8'(d));
         n = 0;
         for (int i = 1; i <= 3 * d; i++) begin
            l = SW'($urandom); r = SW'($urandom);
            adv(l, r, sv, so);
            chk($sformatf("dec%0d_adv%0d", d, i), sv, (i % d) == 0);
            if (sv) begin
               n++;
               chk("dec_out", so, ref_sample(0, l, r));
            end
         end
         chk("dec_strobes", n, 3);
      end
      wr(RB + 6, 8'h00);
      for (int i = 0; i < 5; i++) begin
         adv(SW'($urandom), SW'($urandom), sv, so);
         chk("dec0_every", sv, 1);
      end
      wr(RB + 6, 8'h01);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         if (i >= 2) begin
            chk("b2b_rdv", bus.readdatavalid, 1);
            chk($sformatf("b2b_byte%0d", i - 2), bus.readdata, 8'(32'hA1B2C3D4 >> (8 * (i - 2))));
         end else chk("b2b_rdv_lead", bus.readdatavalid, 0);
         if (i < 4) begin
            bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = AW'(20 + i);
         end else bus_idle();
         @(negedge clk);
      end
      chk("b2b_rdv_tail", bus.readdatavalid, 0);
      for (int i = 0; i < 10; i++) begin
         a = int'($urandom_range(0, RB - 1));
         w = mem[a / 4];
         rd(a, 8'(w >> (8 * (a % 4))), $sformatf("bin_rd_%0d", a));
      end
      rd(RB + 8, 8'h00, "unmapped_rd");
      wr(RB + 5, 8'h02);
      wr(RB + 9, 8'h01);
      rd(RB + 5, 8'h02, "unmapped_wr_ignored");
      @(negedge clk);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b1; bus.address = AW'(RB + 5); bus.writedata = 8'h01;
      @(negedge clk);
      bus_idle();
      @(negedge clk);
      chk("rw_same_no_rdv", bus.readdatavalid, 0);
      @(negedge clk);
      chk("rw_same_no_rdv2", bus.readdatavalid, 0);
      rd(RB + 5, 8'h01, "rw_same_write_wins");
      repeat (7) fedge();
      wr(RB + 7, 8'h01);
      repeat (3) fedge();
      rd(RB + 0, 8'h07, "cnt_shadow");
      rd(RB + 1, 8'h00, "cnt_upper_zero");
      rd(RB + 7, 8'h01, "ctl_rb");
      chk("lock_out", output_being_read, 1);
      wr(RB + 7, 8'h00);
      rd(RB + 0, 8'(cnt_m), "cnt_live");
      chk("unlock_out", output_being_read, 0);
      @(negedge clk);
      frame_valid = 1'b1;
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = AW'(RB + 7); bus.writedata = 8'h01;
      @(negedge clk);
      bus_idle();
      frame_valid = 1'b0;
      rd(RB + 0, 8'(cnt_m), "cnt_same_cycle_edge_excluded");
      cnt_m = (cnt_m + 1) % (1 << CW);
      wr(RB + 7, 8'h00);
      rd(RB + 0, 8'(cnt_m), "cnt_after_same_cycle");
      while (cnt_m != (1 << CW) - 1) fedge();
      rd(RB + 0, 8'hFF, "cnt_max");
      fedge();
      rd(RB + 0, 8'h00, "cnt_wrap");
      rd(RB + 4, 8'h00, "status_idle");
      wr(RB + 7, 8'h01);
      repeat (80) @(negedge clk);
      wr(RB + 7, 8'h01);
      repeat (80) @(negedge clk);
      chk("wd_restart_still_locked", output_being_read, 1);
      wr(RB + 7, 8'h00);
      wr(RB + 7, 8'h01);
      repeat (HT - 6) @(negedge clk);
      chk("wd_before_timeout", output_being_read, 1);
      repeat (12) @(negedge clk);
      chk("wd_timeout_drop", output_being_read, 0);
      rd(RB + 4, 8'h04, "status_timeout_rderr1");
      read_error = 1'b0;
      rd(RB + 4, 8'h05, "status_timeout_rderr0");
      rd(RB + 7, 8'h00, "ctl_after_timeout");
      wr(RB + 4, 8'hA5);
      rd(RB + 4, 8'h01, "status_cleared");
      @(negedge clk);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = AW'(RB + 5);
      @(posedge clk);
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      @(negedge clk);
      bus_idle();
      chk("rst_mid_read_rdv", bus.readdatavalid, 0);
      @(negedge clk);
      chk("rst_mid_read_rdv2", bus.readdatavalid, 0);
      rd(RB + 5, 8'h00, "rst_mid_mode");
      rd(RB + 6, 8'h01, "rst_mid_decim");
      rd(RB + 0, 8'h00, "rst_mid_cnt");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
